// File: rtl/frame_slide_pkg.sv
// Shared types and constants for the frame-slide channel scheduler.
package frame_slide_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCtrl,
        StWeight,
        StImg,
        StWaitDone,
        StNext
    } state_e;

    localparam int unsigned NUM_WEIGHTS = 9;
    localparam int unsigned MAX_SIZE    = 416;

    // Control-word field positions.
    localparam int unsigned SIZE_LSB = 2;
    localparam int unsigned SIZE_MSB = 10;
    localparam int unsigned DIM_LSB  = 0;
    localparam int unsigned DIM_MSB  = 1;

    // Build the per-channel control word: image side plus datapath lane select.
    function automatic logic [63:0] ctrl_word(input logic [8:0] size, input logic [1:0] lane);
        logic [63:0] w;
        w                  = '0;
        w[SIZE_MSB:SIZE_LSB] = size;
        w[DIM_MSB:DIM_LSB]   = lane;
        return w;
    endfunction

endpackage

// File: rtl/frame_slide_beat_cnt.sv
// Loadable down-counter with terminal flag; counts the WEIGHT and IMG beats.
module frame_slide_beat_cnt #(
    parameter int unsigned BEAT_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BEAT_W-1:0] load_val,
    input  logic              dec,
    output logic              term
);

    logic [BEAT_W-1:0] count_q;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - BEAT_W'(1);
        end
    end

    assign term = (count_q == '0);

endmodule

// File: rtl/frame_slide_sched.sv
// Channel scheduler for the frame-slide datapath: per channel it issues one control
// word, 9 weight beats and size*size image beats, then waits for the datapath done.
// Optional watchdog in WAIT_DONE: define FRAME_SLIDE_SCHED_WDOG_EN (adds err_wdog).
// MAX_SIZE comes from frame_slide_pkg; BEAT_W must satisfy 2^BEAT_W > MAX_SIZE^2.
module frame_slide_sched #(
    parameter int unsigned CH_W   = 10,
    parameter int unsigned BEAT_W = 18
`ifdef FRAME_SLIDE_SCHED_WDOG_EN
    ,
    parameter int unsigned WDOG_CYC = 1048576
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [8:0]      cfg_img_size,
    input  logic [CH_W-1:0] cfg_num_ch,
    input  logic            src_valid,
    input  logic [63:0]     src_data,
    output logic            src_ready,
    output logic [63:0]     fs_data,
    output logic            fs_chip_en,
    output logic            fs_rst,
    input  logic            fs_done,
    output logic [CH_W-1:0] ch_idx,
    output logic            busy,
    output logic            done,
    output logic            err_cfg,
    output logic            err_underrun
`ifdef FRAME_SLIDE_SCHED_WDOG_EN
    ,
    output logic            err_wdog
`endif
);

    import frame_slide_pkg::*;

    state_e            state_q, state_d;
    logic [8:0]        size_q;
    logic [CH_W-1:0]   num_ch_q;
    logic [CH_W-1:0]   ch_idx_q;
    logic              err_underrun_q;
    logic              fs_rst_q;

    logic              cfg_ok;
    logic              start_ok;
    logic              last_ch;
    logic              underrun;
    logic              wdog_fire;
    logic              cnt_load;
    logic [BEAT_W-1:0] cnt_load_val;
    logic              cnt_term;
    logic [BEAT_W-1:0] img_beats;

    assign cfg_ok    = (cfg_img_size >= 9'd3) && (cfg_img_size <= 9'(MAX_SIZE))
                       && (cfg_num_ch != '0);
    assign start_ok  = (state_q == StIdle) && start && cfg_ok && !abort;
    assign last_ch   = (ch_idx_q == num_ch_q - CH_W'(1));
    // Full-width product: 416*416 needs all 18 bits.
    assign img_beats = BEAT_W'(size_q) * BEAT_W'(size_q);

    frame_slide_beat_cnt #(
        .BEAT_W (BEAT_W)
    ) u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      ((state_q == StWeight) || (state_q == StImg)),
        .term     (cnt_term)
    );

    // Next-state logic and beat-counter loads; abort overrides every transition.
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            StIdle: begin
                if (start && cfg_ok) state_d = StCtrl;
            end
            StCtrl: begin
                state_d      = StWeight;
                cnt_load     = 1'b1;
                cnt_load_val = BEAT_W'(NUM_WEIGHTS - 1);
            end
            StWeight: begin
                if (cnt_term) begin
                    state_d      = StImg;
                    cnt_load     = 1'b1;
                    cnt_load_val = img_beats - BEAT_W'(1);
                end
            end
            StImg: begin
                if (cnt_term) state_d = StWaitDone;
            end
            StWaitDone: begin
                if (fs_done) state_d = StNext;
                else if (wdog_fire) state_d = StIdle;
            end
            StNext: begin
                state_d = last_ch ? StIdle : StCtrl;
            end
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    // Moore-style stream outputs; data passes straight through since the datapath never stalls.
    always_comb begin
        fs_data    = '0;
        src_ready  = 1'b0;
        fs_chip_en = 1'b0;
        done       = 1'b0;
        err_cfg    = 1'b0;
        underrun   = 1'b0;
        case (state_q)
            StIdle: err_cfg = start && !cfg_ok && !abort;
            StCtrl: begin
                fs_chip_en = 1'b1;
                fs_data    = ctrl_word(size_q, ch_idx_q[1:0]);
            end
            StWeight, StImg: begin
                src_ready = 1'b1;
                if (src_valid) fs_data = src_data;
                else underrun = 1'b1;
            end
            StNext: done = last_ch && !abort;
            default: ;
        endcase
    end

    // State, latched config, channel index and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            size_q         <= '0;
            num_ch_q       <= '0;
            ch_idx_q       <= '0;
            err_underrun_q <= 1'b0;
            fs_rst_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            fs_rst_q <= abort || wdog_fire;
            if (start_ok) begin
                size_q         <= cfg_img_size;
                num_ch_q       <= cfg_num_ch;
                ch_idx_q       <= '0;
                err_underrun_q <= 1'b0;
            end else begin
                if (underrun) err_underrun_q <= 1'b1;
                // ch_idx is held on abort so the controller can see where it stopped.
                if ((state_q == StNext) && !last_ch && !abort) ch_idx_q <= ch_idx_q + CH_W'(1);
            end
        end
    end

`ifdef FRAME_SLIDE_SCHED_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYC) + 1;

    logic [WD_W-1:0] wdog_q;
    logic            err_wdog_q;

    // fs_done in the expiry cycle still wins.
    assign wdog_fire = (state_q == StWaitDone) && !fs_done && (wdog_q == WD_W'(WDOG_CYC - 1));

    // Count consecutive WAIT_DONE cycles; sticky error on expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q     <= '0;
            err_wdog_q <= 1'b0;
        end else begin
            wdog_q <= ((state_q == StWaitDone) && (state_d == StWaitDone)) ?
                      wdog_q + WD_W'(1) : '0;
            if (start_ok) err_wdog_q <= 1'b0;
            else if (wdog_fire) err_wdog_q <= 1'b1;
        end
    end

    assign err_wdog = err_wdog_q;
`else
    assign wdog_fire = 1'b0;
`endif

    assign fs_rst       = rst || fs_rst_q;
    assign busy         = (state_q != StIdle);
    assign ch_idx       = ch_idx_q;
    assign err_underrun = err_underrun_q;

endmodule

// File: doc/frame_slide_sched.md
Name: frame_slide_sched

Overview:
Channel scheduler sitting in front of the frame-slide/convolution datapath. For each input channel of a layer it issues one control word, 9 weight beats and size*size image beats on a no-stall 64-bit stream. It then waits for the datapath's done pulse and advances to the next channel. It pulls data from an upstream ready/valid source (DMA/FIFO) and reports progress and errors to the layer controller.

Parameters:
MAX_SIZE, 416, largest legal image side; legal cfg_img_size range is 3..MAX_SIZE.
CH_W, 10, width of channel count/index.
BEAT_W, 18, beat counter width; must satisfy 2^BEAT_W > MAX_SIZE^2.
WDOG_CYC, 1048576, watchdog limit in WAIT_DONE (optional feature only).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  layer start pulse; sampled only in IDLE
abort  in  1  synchronous abort, any state
cfg_img_size  in  9  image side, sampled at accepted start
cfg_num_ch  in  CH_W  channel count, sampled at accepted start; 0 is illegal
src_valid  in  1  source beat valid
src_data  in  64  source beat (weights, then image)
src_ready  out  1  beat taken this cycle
fs_data  out  64  datapath data word
fs_chip_en  out  1  control-word strobe to datapath
fs_rst  out  1  datapath reset
fs_done  in  1  datapath channel-complete pulse
ch_idx  out  CH_W  channel currently scheduled
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the layer completes
err_cfg  out  1  one-cycle pulse when a start is rejected
err_underrun  out  1  sticky; cleared by the next accepted start or by rst

Behaviour:
- Reset: state IDLE. fs_rst=1 while rst is high. All other outputs 0; ch_idx=0.
- IDLE:
  - start with 3<=cfg_img_size<=MAX_SIZE and cfg_num_ch!=0: latch cfg, ch_idx<=0, clear err_underrun, go to CTRL.
  - Otherwise start only pulses err_cfg; state stays IDLE.
- CTRL (1 cycle):
  - fs_chip_en=1.
  - fs_data = {53'b0, size[8:0], ch_idx[1:0]}; lane select is ch_idx[1:0].
  - src_ready=0. Next state WEIGHT.
- WEIGHT (exactly 9 cycles), then IMG (exactly size*size cycles):
  - src_ready=1 every cycle.
  - fs_data=src_data when src_valid, otherwise 0 and err_underrun<=1.
  - The beat is counted either way, because the datapath cannot stall.
  - The beat counter resets on entry to each state. Leave IMG when the counter equals size*size-1 (18-bit product, no truncation).
- WAIT_DONE:
  - fs_data=0, src_ready=0.
  - fs_done moves to NEXT. fs_done seen in any other state is ignored.
- NEXT (1 cycle):
  - If ch_idx==num_ch-1: done=1, go to IDLE.
  - Otherwise ch_idx+1, go to CTRL. The datapath idles with chip_en low in this cycle.
- fs_chip_en is high only in CTRL. src_ready is 0 in IDLE, CTRL, WAIT_DONE and NEXT.
- abort:
  - Priority over every transition, including start and fs_done in the same cycle.
  - Next state IDLE. fs_rst=1 for exactly one cycle (the cycle after abort). No done pulse. ch_idx is held for debug.
- start while busy is ignored (no err_cfg).
- Latency: start accepted at cycle 0 → CTRL at cycle 1 → first weight at cycle 2 → first image beat at cycle 11.

Optional Feature:
FRAME_SLIDE_SCHED_WDOG_EN
- Defined:
  - A counter runs in WAIT_DONE.
  - On reaching WDOG_CYC without fs_done, the block pulses fs_rst for one cycle, asserts a sticky err_wdog output (cleared at the next accepted start or rst) and goes to IDLE without a done pulse.
- Undefined: the err_wdog port is absent and WAIT_DONE waits indefinitely.

Decomposition:
- Shared package frame_slide_pkg holds:
  - state enum (IDLE, CTRL, WEIGHT, IMG, WAIT_DONE, NEXT);
  - NUM_WEIGHTS=9;
  - control-word field positions (SIZE_LSB=2, SIZE_MSB=10, DIM_LSB=0, DIM_MSB=1);
  - MAX_SIZE.
- One natural sub-module, frame_slide_beat_cnt: loadable BEAT_W-bit down-counter with a terminal flag, reused for WEIGHT and IMG.

Test Plan:
- size=5, num_ch=1, src_valid always high: fs_chip_en at cycle 1 with fs_data=0x14; 9 weight beats then 25 image beats, each equal to src_data; src_ready low afterwards; fs_done at cycle 60 → done pulse at cycle 61; busy low at cycle 62.
- size=3, num_ch=6: ch_idx walks 0..5; control-word lane bits read 0,1,2,3,0,1; exactly 6 fs_chip_en pulses and 1 done.
- size=2, then size=417, then num_ch=0: err_cfg pulses each time; busy stays 0.
- size=4: drop src_valid for 2 cycles mid-IMG → those fs_data words are 0; err_underrun=1; beat count unchanged (16); layer still completes; next start clears err_underrun.
- abort in the same cycle as fs_done during WAIT_DONE: no done pulse; one-cycle fs_rst; IDLE next cycle; new start accepted normally.
- With FRAME_SLIDE_SCHED_WDOG_EN and WDOG_CYC=100, fs_done withheld: err_wdog sets after 100 WAIT_DONE cycles, fs_rst pulses, block returns to IDLE.
